decode_queue: RTL and testbench

- Parametrised instruction front-end for the decode stage; generalises the single-entry hazard skid register to a DEPTH-entry FIFO.
- Captures fetched words while the pipeline is stalled by `hazard`, then replays them in order. Adds redirect flush, a fetch back-pressure signal, and registered predecode flags.
- Sits between instruction memory and the decode unit, and drives the decoder's instruction register.
- With DEPTH=1 and flush tied low, cycle behaviour matches the existing stall handling.

---
 rtl/decode_queue.sv | 159 +++++++++++++++
 tb/tb_decode_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
//
// Instruction front-end for the decode stage. Fetched words pass straight
// into the decoder's instruction register when the pipeline advances and the
// queue is empty. While `hazard` stalls decode, fetched words are captured in
// a DEPTH-entry FIFO and replayed in arrival order once the stall clears.
// A redirect (`flush`) discards everything queued or in flight.
// Predecode flags are registered together with I_out so they never lag it.
//
// Ports:
//   clk          clock
//   RST          synchronous, active-high reset (overrides everything)
//   hazard       downstream stall; I_out and its flags hold while high
//   flush        redirect; empties the queue and clears I_out
//   I_in         fetched instruction word
//   I_valid      I_in is a valid fetch this cycle
//   I_out        instruction presented to decode (registered)
//   I_out_valid  I_out holds a real instruction
//   op_class     registered I_out[IW-1:IW-3]
//   long_I       registered ~I_out[IW-4]
//   is_ctrl      registered; op_class is 4 (xec), 5 (nzt) or 7 (jmp)
//   fetch_hold   queue full; fetch must not assert I_valid next cycle
//   count        queue occupancy, not including I_out
//   overflow     sticky; a valid word arrived while the queue was full
//
// Handshake: there is no ready signal on the fetch side. A word with
// I_valid=1 is accepted in the cycle it is presented unless the queue is full
// during a stall, in which case it is dropped and overflow is set. fetch_hold
// is the back-pressure hint and depends only on the count register.
// -----------------------------------------------------------------------------
module decode_queue #(
    parameter int IW    = 16,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          hazard,
    input  logic          flush,
    input  logic [IW-1:0] I_in,
    input  logic          I_valid,
    output logic [IW-1:0] I_out,
    output logic          I_out_valid,
    output logic [2:0]    op_class,
    output logic          long_I,
    output logic          is_ctrl,
    output logic          fetch_hold,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          load;
    logic          drop;
    logic [IW-1:0] load_word;
    logic          load_valid;

    // Explicit compare so non-power-of-two depths wrap correctly.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign fetch_hold = full;

    // Datapath control. RST and flush suppress every queue side effect,
    // including the write of a word arriving in the same cycle.
    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;
        drop       = 1'b0;
        load_word  = I_in;
        load_valid = I_valid;
        if (!RST && !flush) begin
            if (!hazard) begin
                load = 1'b1;
                if (!empty) begin
                    // Replay head; a concurrent fetch takes the freed slot.
                    pop        = 1'b1;
                    load_word  = mem[rd_ptr];
                    load_valid = 1'b1;
                    push       = I_valid;
                end
            end else begin
                push = I_valid && !full;
                drop = I_valid && full;
            end
        end
    end

    // Queue storage carries no reset; contents are meaningless when count=0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= I_in;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            I_out       <= '0;
            I_out_valid <= 1'b0;
            op_class    <= 3'd0;
            long_I      <= 1'b1;
            is_ctrl     <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            I_out       <= '0;
            I_out_valid <= 1'b0;
            op_class    <= 3'd0;
            long_I      <= 1'b1;
            is_ctrl     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            // Flags are derived from the word being loaded, not from I_out,
            // so they change on the same edge as I_out.
            if (load) begin
                I_out       <= load_word;
                I_out_valid <= load_valid;
                op_class    <= load_word[IW-1:IW-3];
                long_I      <= ~load_word[IW-4];
                is_ctrl     <= (load_word[IW-1:IW-3] == 3'd4) ||
                               (load_word[IW-1:IW-3] == 3'd5) ||
                               (load_word[IW-1:IW-3] == 3'd7);
            end
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

    localparam int IW = 16;

    logic          clk;
    logic          RST;
    logic          hazard;
    logic          flush;
    logic [IW-1:0] I_in;
    logic          I_valid;

    // DEPTH=2 instance for the directed vectors
    logic [IW-1:0] out2;
    logic          v2, li2, ic2, fh2, ov2;
    logic [2:0]    oc2;
    logic [1:0]    cnt2;

    // DEPTH=3 instance for the randomized regression
    logic [IW-1:0] out3;
    logic          v3, li3, ic3, fh3, ov3;
    logic [2:0]    oc3;
    logic [1:0]    cnt3;

    int tests;
    int fails;

    decode_queue #(.IW(IW), .DEPTH(2)) dut2 (
        .clk(clk), .RST(RST), .hazard(hazard), .flush(flush),
        .I_in(I_in), .I_valid(I_valid),
        .I_out(out2), .I_out_valid(v2), .op_class(oc2), .long_I(li2),
        .is_ctrl(ic2), .fetch_hold(fh2), .count(cnt2), .overflow(ov2)
    );

    decode_queue #(.IW(IW), .DEPTH(3)) dut3 (
        .clk(clk), .RST(RST), .hazard(hazard), .flush(flush),
        .I_in(I_in), .I_valid(I_valid),
        .I_out(out3), .I_out_valid(v3), .op_class(oc3), .long_I(li3),
        .is_ctrl(ic3), .fetch_hold(fh3), .count(cnt3), .overflow(ov3)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares one instance's outputs against expected word/valid/count/
    // overflow; predecode and fetch_hold expectations follow from those.
    task automatic check_outputs(input string tag, input int depth,
                                 input logic [IW-1:0] a_out, input logic a_v,
                                 input logic [2:0] a_oc, input logic a_li,
                                 input logic a_ic, input logic a_fh,
                                 input logic [1:0] a_cnt, input logic a_ov,
                                 input logic [IW-1:0] e_out, input logic e_v,
                                 input int e_cnt, input logic e_ov);
        int e_op;
        e_op = int'(e_out[15:13]);
        check({tag, ".I_out"},       int'(a_out), int'(e_out));
        check({tag, ".I_out_valid"}, int'(a_v),   int'(e_v));
        check({tag, ".count"},       int'(a_cnt), e_cnt);
        check({tag, ".fetch_hold"},  int'(a_fh),  (e_cnt == depth) ? 1 : 0);
        check({tag, ".overflow"},    int'(a_ov),  int'(e_ov));
        check({tag, ".op_class"},    int'(a_oc),  e_op);
        check({tag, ".long_I"},      int'(a_li),  e_out[12] ? 0 : 1);
        check({tag, ".is_ctrl"},     int'(a_ic),
              (e_op == 4 || e_op == 5 || e_op == 7) ? 1 : 0);
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic r, input logic f, input logic h,
                               input logic v, input logic [IW-1:0] d);
        RST     = r;
        flush   = f;
        hazard  = h;
        I_valid = v;
        I_in    = d;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vectors (DEPTH=2) ----------------
    typedef struct {
        logic          rst, fl, hz, vin;
        logic [IW-1:0] din;
        logic [IW-1:0] e_out;
        logic          e_v;
        int            e_cnt;
        logic          e_ov;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic fl, input logic hz,
                                input logic vin, input logic [IW-1:0] din,
                                input logic [IW-1:0] e_out, input logic e_v,
                                input int e_cnt, input logic e_ov);
        vec_t t;
        t.rst = rst; t.fl = fl; t.hz = hz; t.vin = vin; t.din = din;
        t.e_out = e_out; t.e_v = e_v; t.e_cnt = e_cnt; t.e_ov = e_ov;
        return t;
    endfunction

    vec_t tbl[24];

    // ---------------- reference model (DEPTH=3) ----------------
    localparam int MD = 3;
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] m_out;
    logic          m_v;
    logic          m_ov;

    task automatic model_step(input logic r, input logic f, input logic h,
                              input logic v, input logic [IW-1:0] d);
        if (r) begin
            exp_q.delete();
            m_out = '0; m_v = 1'b0; m_ov = 1'b0;
        end else if (f) begin
            exp_q.delete();
            m_out = '0; m_v = 1'b0;
        end else if (!h) begin
            if (exp_q.size() > 0) begin
                m_out = exp_q.pop_front();
                m_v   = 1'b1;
                if (v) exp_q.push_back(d);
            end else begin
                m_out = d;
                m_v   = v;
            end
        end else if (v) begin
            if (exp_q.size() < MD) exp_q.push_back(d);
            else m_ov = 1'b1;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        RST = 1'b1; flush = 1'b0; hazard = 1'b0; I_valid = 1'b0; I_in = '0;

        //             rst fl hz v  din       e_out     e_v cnt ov
        tbl[0]  = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        // bypass stream, one-cycle latency
        tbl[1]  = mk(0, 0, 0, 1, 16'h2105, 16'h2105, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 16'h6A03, 16'h6A03, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 16'hE123, 16'hE123, 1, 0, 0);
        // 3-cycle stall into a 2-deep queue: third word dropped
        tbl[4]  = mk(0, 0, 1, 1, 16'h1111, 16'hE123, 1, 1, 0);
        tbl[5]  = mk(0, 0, 1, 1, 16'h2222, 16'hE123, 1, 2, 0);
        tbl[6]  = mk(0, 0, 1, 1, 16'h3333, 16'hE123, 1, 2, 1);
        tbl[7]  = mk(0, 0, 0, 0, 16'h0000, 16'h1111, 1, 1, 1);
        tbl[8]  = mk(0, 0, 0, 0, 16'h0000, 16'h2222, 1, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
        // fill, then pop and push in the same cycle
        tbl[10] = mk(0, 0, 1, 1, 16'h1111, 16'h0000, 0, 1, 1);
        tbl[11] = mk(0, 0, 1, 1, 16'h2222, 16'h0000, 0, 2, 1);
        tbl[12] = mk(0, 0, 0, 1, 16'h4444, 16'h1111, 1, 2, 1);
        tbl[13] = mk(0, 0, 0, 0, 16'h0000, 16'h2222, 1, 1, 1);
        tbl[14] = mk(0, 0, 0, 0, 16'h0000, 16'h4444, 1, 0, 1);
        // flush with a full queue and a word arriving
        tbl[15] = mk(0, 0, 1, 1, 16'h7777, 16'h4444, 1, 1, 1);
        tbl[16] = mk(0, 0, 1, 1, 16'h8888, 16'h4444, 1, 2, 1);
        tbl[17] = mk(0, 1, 0, 1, 16'h5555, 16'h0000, 0, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
        tbl[19] = mk(0, 0, 0, 1, 16'h9999, 16'h9999, 1, 0, 1);
        // reset mid-stall with a full queue
        tbl[20] = mk(0, 0, 1, 1, 16'hAAAA, 16'h9999, 1, 1, 1);
        tbl[21] = mk(0, 0, 1, 1, 16'hBBBB, 16'h9999, 1, 2, 1);
        tbl[22] = mk(1, 0, 1, 1, 16'hCCCC, 16'h0000, 0, 0, 0);
        tbl[23] = mk(0, 0, 0, 1, 16'h1234, 16'h1234, 1, 0, 0);

        for (int i = 0; i < 24; i++) begin
            drive_cycle(tbl[i].rst, tbl[i].fl, tbl[i].hz, tbl[i].vin, tbl[i].din);
            check_outputs($sformatf("vec%0d", i), 2,
                          out2, v2, oc2, li2, ic2, fh2, cnt2, ov2,
                          tbl[i].e_out, tbl[i].e_v, tbl[i].e_cnt, tbl[i].e_ov);
        end

        // ---------------- randomized regression (DEPTH=3) ----------------
        for (int p = 0; p < 10; p++) begin
            int hz_pct;
            int v_pct;
            hz_pct = 10 + p * 8;
            v_pct  = 40 + (p % 4) * 20;
            drive_cycle(1, 0, 0, 0, '0);
            model_step(1, 0, 0, 0, '0);
            check_outputs($sformatf("rnd%0d.rst", p), MD,
                          out3, v3, oc3, li3, ic3, fh3, cnt3, ov3,
                          m_out, m_v, exp_q.size(), m_ov);
            for (int c = 0; c < 200; c++) begin
                logic          r, f, h, v;
                logic [IW-1:0] d;
                r = ($urandom_range(0, 199) == 0);
                f = ($urandom_range(0, 39) == 0);
                h = ($urandom_range(0, 99) < hz_pct);
                v = ($urandom_range(0, 99) < v_pct);
                d = IW'($urandom);
                drive_cycle(r, f, h, v, d);
                model_step(r, f, h, v, d);
                check_outputs($sformatf("rnd%0d.c%0d", p, c), MD,
                              out3, v3, oc3, li3, ic3, fh3, cnt3, ov3,
                              m_out, m_v, exp_q.size(), m_ov);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
